// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Data wins ties unless fetch has been starved for STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int unsigned        AWIDTH     = 32,
  parameter int unsigned        DWIDTH     = 32,
  parameter logic [AWIDTH-1:0]  BASE_ADDR  = 32'h0100_0000,
  parameter int unsigned        MEM_BYTES  = 1048576,
  parameter int unsigned        STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  output logic              if_err_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  input  logic [2:0]        d_funct3_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  output logic              d_err_o,
  output logic [AWIDTH-1:0] mem_pc_o,
  output logic              mem_ren_o,
  input  logic [DWIDTH-1:0] mem_insn_i,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic [2:0]        mem_funct3_o,
  output logic              mem_memren_o,
  output logic              mem_wen_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

  localparam int unsigned       CW    = 4;
  localparam logic [CW-1:0]     SMAX  = CW'(STARVE_MAX);
  localparam logic [AWIDTH:0]   LIMIT = {1'b0, BASE_ADDR} + (AWIDTH+1)'(MEM_BYTES);

  typedef enum logic {ARB, FETCH_FORCE} state_t;

  typedef struct packed {
    logic              vld;
    logic              err;
    logic [DWIDTH-1:0] data;
  } rsp_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     starve_q, starve_d;
  rsp_t              if_rsp_q, d_rsp_q;
  logic [AWIDTH-1:0] pc_q, addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [2:0]        f3_q;
  logic              if_fault, d_fault, d_mis, d_f3_bad, d_acc;

  // The whole access (addr .. addr+3) must fit inside the window.
  function automatic logic out_of_range(input logic [AWIDTH-1:0] a);
    logic [AWIDTH:0] last;
    last = {1'b0, a} + (AWIDTH+1)'(3);
    return (a < BASE_ADDR) || (last >= LIMIT);
  endfunction

  assign if_fault = (if_addr_i[1:0] != 2'b00) || out_of_range(if_addr_i);

  always_comb begin
    d_mis    = 1'b0;
    d_f3_bad = 1'b0;
    case (d_funct3_i)
      3'b000:  d_mis = 1'b0;
      3'b001:  d_mis = d_addr_i[0];
      3'b010:  d_mis = |d_addr_i[1:0];
      3'b100:  d_f3_bad = d_we_i;
      3'b101:  begin d_f3_bad = d_we_i; d_mis = d_addr_i[0]; end
      default: d_f3_bad = 1'b1;
    endcase
  end

  assign d_fault = d_f3_bad || d_mis || out_of_range(d_addr_i);

  assign d_gnt_o  = rst & d_req_i & ~(if_req_i & (state_q == FETCH_FORCE));
  assign if_gnt_o = rst & if_req_i & ~d_gnt_o;

  assign d_acc        = d_gnt_o & ~d_fault;
  assign mem_ren_o    = if_gnt_o & ~if_fault;
  assign mem_memren_o = d_acc & ~d_we_i;
  assign mem_wen_o    = d_acc & d_we_i;

  // Address/data lines follow the granted request, otherwise hold.
  assign mem_pc_o     = mem_ren_o ? if_addr_i  : pc_q;
  assign mem_addr_o   = d_acc     ? d_addr_i   : addr_q;
  assign mem_funct3_o = d_acc     ? d_funct3_i : f3_q;
  assign mem_wdata_o  = mem_wen_o ? d_wdata_i  : wdata_q;

  always_comb begin
    starve_d = starve_q;
    state_d  = state_q;
    if (if_gnt_o || !if_req_i)
      starve_d = '0;
    else if (d_gnt_o && (starve_q < SMAX))
      starve_d = starve_q + 1'b1;
    case (state_q)
      ARB:         if (if_req_i && (starve_d == SMAX)) state_d = FETCH_FORCE;
      FETCH_FORCE: if (if_gnt_o || !if_req_i)          state_d = ARB;
      default:     state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB;
      starve_q <= '0;
      if_rsp_q <= '0;
      d_rsp_q  <= '0;
      pc_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      f3_q     <= '0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      if_rsp_q.vld  <= if_gnt_o;
      if_rsp_q.err  <= if_gnt_o & if_fault;
      if_rsp_q.data <= mem_ren_o ? mem_insn_i : '0;
      d_rsp_q.vld   <= d_gnt_o;
      d_rsp_q.err   <= d_gnt_o & d_fault;
      d_rsp_q.data  <= mem_memren_o ? mem_data_i : '0;
      pc_q          <= mem_pc_o;
      addr_q        <= mem_addr_o;
      f3_q          <= mem_funct3_o;
      wdata_q       <= mem_wdata_o;
    end
  end

  assign if_rvalid_o = if_rsp_q.vld;
  assign if_err_o    = if_rsp_q.err;
  assign if_rdata_o  = if_rsp_q.data;
  assign d_rvalid_o  = d_rsp_q.vld;
  assign d_err_o     = d_rsp_q.err;
  assign d_rdata_o   = d_rsp_q.data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: request queues, reference model
// predicting grants and responses, and a decoupled response monitor.
module tb_mem_port_arbiter;
  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam int unsigned MB   = 1048576;
  localparam int unsigned SMAX = 4;

  logic        clk, rst;
  logic        if_req_i, if_gnt_o, if_rvalid_o, if_err_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        d_req_i, d_we_i, d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic [2:0]  d_funct3_i, mem_funct3_o;
  logic [31:0] mem_pc_o, mem_insn_i, mem_addr_o, mem_wdata_o, mem_data_i;
  logic        mem_ren_o, mem_memren_o, mem_wen_o;

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .BASE_ADDR(BASE),
                     .MEM_BYTES(MB), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_funct3_i(d_funct3_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .mem_pc_o(mem_pc_o), .mem_ren_o(mem_ren_o), .mem_insn_i(mem_insn_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_funct3_o(mem_funct3_o),
    .mem_memren_o(mem_memren_o), .mem_wen_o(mem_wen_o), .mem_data_i(mem_data_i));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata; } dreq_t;
  typedef struct { bit err; logic [31:0] data; } rsp_t;

  logic [31:0] if_sq [$];
  dreq_t       d_sq  [$];
  rsp_t        if_eq [$];
  rsp_t        d_eq  [$];
  logic [7:0]  emem [0:4095];
  logic [7:0]  mmem [0:4095];
  int          ncmp = 0, nerr = 0, d_grants = 0;
  bit          if_taken = 1'b0, d_taken = 1'b0;
  int unsigned dwins = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    ncmp++;
    if (act !== exp) begin nerr++; $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time); end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin nerr++; $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time); end
  endtask

  function automatic logic [11:0] ix(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off[11:0];
  endfunction

  // ---------------- memory block stand-in ----------------
  logic [31:0] ew_pc, ew_d;
  always_comb begin
    ew_pc = {emem[ix(mem_pc_o+32'd3)], emem[ix(mem_pc_o+32'd2)], emem[ix(mem_pc_o+32'd1)], emem[ix(mem_pc_o)]};
    ew_d  = {emem[ix(mem_addr_o+32'd3)], emem[ix(mem_addr_o+32'd2)], emem[ix(mem_addr_o+32'd1)], emem[ix(mem_addr_o)]};
    mem_insn_i = ew_pc;
    case (mem_funct3_o)
      3'b000:  mem_data_i = {{24{ew_d[7]}}, ew_d[7:0]};
      3'b001:  mem_data_i = {{16{ew_d[15]}}, ew_d[15:0]};
      3'b100:  mem_data_i = {24'h0, ew_d[7:0]};
      3'b101:  mem_data_i = {16'h0, ew_d[15:0]};
      default: mem_data_i = ew_d;
    endcase
  end

  initial begin
    for (int i = 0; i < 4096; i++) emem[i] <= 8'(i * 37 + 11);
    emem[0] <= 8'h93; emem[1] <= 8'h00; emem[2] <= 8'h50; emem[3] <= 8'h00;
    forever begin
      @(posedge clk);
      if (mem_wen_o) begin
        emem[ix(mem_addr_o)] <= mem_wdata_o[7:0];
        if (mem_funct3_o != 3'b000) emem[ix(mem_addr_o+32'd1)] <= mem_wdata_o[15:8];
        if (mem_funct3_o == 3'b010) begin
          emem[ix(mem_addr_o+32'd2)] <= mem_wdata_o[23:16];
          emem[ix(mem_addr_o+32'd3)] <= mem_wdata_o[31:24];
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic bit oor(input logic [31:0] a);
    longint la;
    la = longint'({32'h0, a});
    return (la < longint'({32'h0, BASE})) || (la + 3 >= longint'({32'h0, BASE}) + longint'(MB));
  endfunction

  function automatic int dsize(input bit we, input logic [2:0] f3);
    case (f3)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      3'd4: return we ? 0 : 1;
      3'd5: return we ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  function automatic bit data_fault(input dreq_t r);
    int sz;
    sz = dsize(r.we, r.f3);
    if (sz == 0) return 1'b1;
    if ((int'(r.addr[1:0]) % sz) != 0) return 1'b1;
    return oor(r.addr);
  endfunction

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return {mmem[ix(a+32'd3)], mmem[ix(a+32'd2)], mmem[ix(a+32'd1)], mmem[ix(a)]};
  endfunction

  function automatic logic [31:0] mload(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    w = mrd(a);
    case (f3)
      3'd0: return 32'($signed(w[7:0]));
      3'd1: return 32'($signed(w[15:0]));
      3'd4: return {24'h0, w[7:0]};
      3'd5: return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  initial begin
    bit eif, ed, f, fd;
    dreq_t r;
    rsp_t e;
    for (int i = 0; i < 4096; i++) mmem[i] = 8'(i * 37 + 11);
    mmem[0] = 8'h93; mmem[1] = 8'h00; mmem[2] = 8'h50; mmem[3] = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk32("gnt_en_in_reset", {27'b0, if_gnt_o, d_gnt_o, mem_ren_o, mem_memren_o, mem_wen_o}, 32'h0);
        dwins = 0; if_taken = 1'b0; d_taken = 1'b0;
      end else begin
        eif = if_req_i && (!d_req_i || dwins >= SMAX);
        ed  = d_req_i && !eif;
        chk1("if_gnt", if_gnt_o, eif);
        chk1("d_gnt", d_gnt_o, ed);
        f = eif && ((if_addr_i[1:0] != 2'b00) || oor(if_addr_i));
        chk1("mem_ren", mem_ren_o, eif && !f);
        if (eif) begin
          if (!f) chk32("mem_pc", mem_pc_o, if_addr_i);
          e.err = f; e.data = f ? 32'h0 : mrd(if_addr_i);
          if_eq.push_back(e); if_taken = 1'b1;
        end
        r = '{d_we_i, d_funct3_i, d_addr_i, d_wdata_i};
        fd = ed && data_fault(r);
        chk1("mem_memren", mem_memren_o, ed && !fd && !r.we);
        chk1("mem_wen", mem_wen_o, ed && !fd && r.we);
        if (ed) begin
          if (!fd) begin
            chk32("mem_addr", mem_addr_o, r.addr);
            chk32("mem_funct3", {29'b0, mem_funct3_o}, {29'b0, r.f3});
            if (r.we) chk32("mem_wdata", mem_wdata_o, r.wdata);
          end
          e.err = fd; e.data = (fd || r.we) ? 32'h0 : mload(r.f3, r.addr);
          d_eq.push_back(e);
          if (r.we && !fd) begin
            mmem[ix(r.addr)] = r.wdata[7:0];
            if (r.f3 != 3'd0) mmem[ix(r.addr+32'd1)] = r.wdata[15:8];
            if (r.f3 == 3'd2) begin
              mmem[ix(r.addr+32'd2)] = r.wdata[23:16];
              mmem[ix(r.addr+32'd3)] = r.wdata[31:24];
            end
          end
          d_taken = 1'b1; d_grants++;
        end
        if (eif || !if_req_i) dwins = 0;
        else if (ed && dwins < SMAX) dwins++;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    rsp_t e;
    forever begin
      @(posedge clk); #2;
      if (!rst) begin
        if_eq.delete(); d_eq.delete();
        chk32("rvalid_in_reset", {30'b0, if_rvalid_o, d_rvalid_o}, 32'h0);
      end else begin
        if (if_eq.size() > 0) begin
          e = if_eq.pop_front();
          chk1("if_rvalid", if_rvalid_o, 1'b1);
          chk1("if_err", if_err_o, e.err);
          chk32("if_rdata", if_rdata_o, e.data);
        end else chk1("if_rvalid_idle", if_rvalid_o, 1'b0);
        if (d_eq.size() > 0) begin
          e = d_eq.pop_front();
          chk1("d_rvalid", d_rvalid_o, 1'b1);
          chk1("d_err", d_err_o, e.err);
          chk32("d_rdata", d_rdata_o, e.data);
        end else chk1("d_rvalid_idle", d_rvalid_o, 1'b0);
      end
    end
  end

  // ---------------- requester driver: hold until granted ----------------
  initial begin
    if_req_i = 1'b0; if_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_funct3_i = '0;
    forever begin
      @(posedge clk); #1;
      if (if_taken) begin void'(if_sq.pop_front()); if_taken = 1'b0; end
      if (d_taken)  begin void'(d_sq.pop_front());  d_taken  = 1'b0; end
      if_req_i = (if_sq.size() > 0);
      if (if_req_i) if_addr_i = if_sq[0];
      d_req_i = (d_sq.size() > 0);
      if (d_req_i) begin
        d_we_i = d_sq[0].we; d_funct3_i = d_sq[0].f3;
        d_addr_i = d_sq[0].addr; d_wdata_i = d_sq[0].wdata;
      end
    end
  end

  task automatic pushd(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    dreq_t r;
    r = '{we, f3, a, wd};
    d_sq.push_back(r);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((if_sq.size() != 0 || d_sq.size() != 0) && n < 500) begin @(posedge clk); n++; end
    ncmp++;
    if (n >= 500) begin
      nerr++;
      $display("FAIL drain_timeout pending if=%0d d=%0d want 0", if_sq.size(), d_sq.size());
    end
    repeat (3) @(posedge clk);
  endtask

  function automatic logic [31:0] rand_pc();
    int n;
    n = int'($urandom_range(0, 15));
    if (n == 0) return BASE + 32'($urandom_range(0, 255));
    if (n == 1) return ($urandom_range(0, 1) != 0) ? BASE - 32'd4 : BASE + MB;
    return BASE + 32'(4 * $urandom_range(0, 63));
  endfunction

  function automatic dreq_t rand_d();
    dreq_t r;
    logic [2:0] tbl [5];
    int sz;
    tbl = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    r.f3 = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : tbl[$urandom_range(0, 4)];
    r.we = (r.f3 == 3'd4 || r.f3 == 3'd5) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) != 0);
    r.addr = BASE + 32'($urandom_range(0, 255));
    sz = dsize(r.we, r.f3);
    if (sz > 0 && $urandom_range(0, 9) != 0) r.addr = r.addr & ~(32'(sz) - 32'd1);
    r.wdata = $urandom;
    return r;
  endfunction

  initial begin
    int g0, n;
    rst = 1'b1;
    #2 rst = 1'b0;
    // requests held across reset; data must win first after release
    if_sq.push_back(BASE);
    pushd(1'b0, 3'd2, BASE + 32'h8, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    wait_idle();

    // lone fetch of the preloaded instruction word
    if_sq.push_back(BASE);
    wait_idle();

    // both requesters saturated: D,D,D,D,F pattern
    for (int i = 0; i < 15; i++) begin
      if_sq.push_back(BASE + 32'(4 * i));
      pushd(1'b0, 3'd2, BASE + 32'h40 + 32'(4 * i), 32'h0);
    end
    wait_idle();

    // store then dependent loads in back-to-back cycles
    pushd(1'b1, 3'd2, BASE + 32'h100, 32'hDEAD_BEEF);
    pushd(1'b0, 3'd0, BASE + 32'h103, 32'h0);
    pushd(1'b0, 3'd4, BASE + 32'h103, 32'h0);
    pushd(1'b0, 3'd1, BASE + 32'h102, 32'h0);
    pushd(1'b1, 3'd0, BASE + 32'h101, 32'h0000_0055);
    pushd(1'b0, 3'd2, BASE + 32'h100, 32'h0);
    wait_idle();

    // fetch right behind a store to the same word sees the new bytes
    pushd(1'b1, 3'd2, BASE + 32'h200, 32'h00A0_0113);
    if_sq.push_back(BASE + 32'h200);
    wait_idle();

    // fault cases and window edges
    pushd(1'b0, 3'd1, BASE + 32'h101, 32'h0);
    pushd(1'b0, 3'd2, BASE - 32'd4, 32'h0);
    pushd(1'b0, 3'd2, BASE + MB - 32'd4, 32'h0);
    pushd(1'b0, 3'd0, BASE + MB - 32'd3, 32'h0);
    pushd(1'b0, 3'd3, BASE + 32'h10, 32'h0);
    pushd(1'b1, 3'd4, BASE + 32'h10, 32'h1234_5678);
    if_sq.push_back(BASE + 32'd2);
    if_sq.push_back(BASE + MB);
    if_sq.push_back(BASE + MB - 32'd4);
    wait_idle();

    // reset right after a load grant drops its response
    pushd(1'b0, 3'd2, BASE + 32'h10, 32'h0);
    g0 = d_grants; n = 0;
    while (d_grants == g0 && n < 50) begin @(posedge clk); n++; end
    chk1("load_grant_before_reset", (d_grants != g0), 1'b1);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    wait_idle();

    // randomized traffic
    repeat (800) begin
      @(posedge clk);
      if (if_sq.size() < 2 && $urandom_range(0, 2) != 0) if_sq.push_back(rand_pc());
      if (d_sq.size() < 2 && $urandom_range(0, 2) != 0) d_sq.push_back(rand_d());
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
